// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serializer.
// Bytes queued on osc_clk leave LSB first on o_Tx_Serial.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1155,
    parameter int DEPTH        = 16
) (
    input  logic                   osc_clk,
    input  logic                   Reset,
    input  logic                   i_Wr_En,
    input  logic [7:0]             i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    output logic                   o_Tx_Serial,
    output logic                   o_Tx_Active,
    output logic                   o_Tx_Done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    shreg;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_acc;
    logic          pop;
    logic          serial_n;
    logic          active_n;
    logic          done_n;

    assign o_Full  = (count == FULL_CNT);
    assign o_Empty = (count == '0);
    assign o_Count = count;
    assign wr_acc  = i_Wr_En && !o_Full;

    // FIFO storage, written only when the write is accepted
    always_ff @(posedge osc_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    // Pointers, occupancy and sticky overflow; a pop never rescues a write on full
    always_ff @(posedge osc_clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_acc && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!wr_acc && pop) begin
                count <= count - (AW + 1)'(1);
            end
            if (i_Wr_En && o_Full) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    // Serializer state plus registered line outputs, so the pin comes straight off a flop
    always_ff @(posedge osc_clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            o_Tx_Serial <= serial_n;
            o_Tx_Active <= active_n;
            o_Tx_Done   <= done_n;
            if (pop) begin
                shreg <= mem[rd_ptr];
            end
        end
    end

    // Next state, baud counting and the output values for the coming cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!o_Empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        done_n   = (state == STOP) && (state_n == IDLE);
        active_n = (state_n != IDLE);
        serial_n = 1'b1;
        if (state_n == START) begin
            serial_n = 1'b0;
        end else if (state_n == DATA) begin
            serial_n = shreg[idx_n];
        end
    end

endmodule
